// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the mesh-router input path.
//   dir_e        - output/input direction encoding (N, E, S, W, PE)
//   FLAG_BITS    - width of the ifm/filt flag at the packet MSB
//   dest_lsb()   - bit offset of the destination field in a packet
//   xy_route()   - dimension-ordered (X first, then Y) route selection
//   route_legal()- rejects U-turns and Y-to-X turns
package noc_pkg;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_E  = 3'd1,
        DIR_S  = 3'd2,
        DIR_W  = 3'd3,
        DIR_PE = 3'd4
    } dir_e;

    localparam int NUM_DIRS  = 5;
    // Widest address the route helper accepts; callers zero-extend into it.
    localparam int ADDR_MAX  = 16;
    // The ifm/filt flag sits in the top bit, destination directly below it,
    // then the source address, then the payload.
    localparam int FLAG_BITS = 1;

    function automatic int dest_lsb(input int width, input int addr_w);
        return width - FLAG_BITS - addr_w;
    endfunction

    // Upper addr_w/2 bits of an address are X, lower addr_w/2 bits are Y.
    function automatic dir_e xy_route(input logic [ADDR_MAX-1:0] dest,
                                      input logic [ADDR_MAX-1:0] my,
                                      input int                  addr_w);
        logic [ADDR_MAX-1:0] ymask;
        logic [ADDR_MAX-1:0] dx, dy, mx, my_y;
        ymask = (ADDR_MAX'(1) << (addr_w / 2)) - ADDR_MAX'(1);
        dx    = dest >> (addr_w / 2);
        mx    = my >> (addr_w / 2);
        dy    = dest & ymask;
        my_y  = my & ymask;
        if (dx > mx)        return DIR_E;
        else if (dx < mx)   return DIR_W;
        else if (dy > my_y) return DIR_N;
        else if (dy < my_y) return DIR_S;
        else                return DIR_PE;
    endfunction

    function automatic logic route_legal(input dir_e in_type, input dir_e route);
        if (route == in_type)
            return 1'b0;
        if ((in_type == DIR_N || in_type == DIR_S) &&
            (route == DIR_E || route == DIR_W))
            return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock FIFO with first-word-fall-through read port.
//   clk, rst_n        - clock, asynchronous active-low reset (pointers only)
//   push, push_data   - write request and data (ignored when full)
//   pop               - discard head entry (ignored when empty)
//   pop_data          - current head entry
//   full, empty       - status from pointer compare
//   count             - number of stored entries (0..DEPTH)
module noc_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates the full and empty cases when the
    // index bits coincide.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/noc_input_router.sv
// noc_input_router: one router input port. Buffers packets, computes the
// XY route of the FIFO head and forwards it to one of five outputs through a
// single output register; packets whose route is illegal for this input
// direction are discarded and counted.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - input handshake, in_data is the packet
//   out_valid[4:0]       - one-hot request (0 N, 1 E, 2 S, 3 W, 4 PE)
//   out_ready[4:0]       - per-output ready; only the selected one is used
//   out_data             - packet shared by all outputs
//   occupancy            - FIFO entries plus output register (0..DEPTH+1)
//   drop_cnt             - saturating count of discarded packets
//   drop_pulse           - one-cycle pulse per discarded packet
module noc_input_router
    import noc_pkg::*;
#(
    parameter int               WIDTH   = 33,
    parameter int               ADDR_W  = 4,
    parameter logic [ADDR_W-1:0] MY_ADDR = 4'b0101,
    parameter logic [2:0]       IN_TYPE = 3'b000,
    parameter int               DEPTH   = 4,
    parameter int               CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_data,
    output logic [NUM_DIRS-1:0]         out_valid,
    input  logic [NUM_DIRS-1:0]         out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [$clog2(DEPTH+2)-1:0]  occupancy,
    output logic [CNT_W-1:0]            drop_cnt,
    output logic                        drop_pulse
);
    localparam int AW       = $clog2(DEPTH);
    localparam int OCC_W    = $clog2(DEPTH + 2);
    localparam int DEST_LSB = dest_lsb(WIDTH, ADDR_W);

    if (IN_TYPE > 3'd4) begin : g_bad_in_type
        $error("noc_input_router: IN_TYPE must be 0..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_input_router: DEPTH must be a power of two >= 2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic                 active;
    logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [WIDTH-1:0]     head;
    logic [AW:0]          fifo_count;
    logic [ADDR_W-1:0]    head_dest;
    dir_e                 route;
    logic                 legal;
    logic                 out_full;
    logic [NUM_DIRS-1:0]  sel;
    logic                 fire, load, drop;

    // in_ready is held low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active <= 1'b0;
        else        active <= 1'b1;
    end

    assign in_ready  = active && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    noc_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_dest = head[DEST_LSB +: ADDR_W];
    assign route     = xy_route(ADDR_MAX'(head_dest), ADDR_MAX'(MY_ADDR), ADDR_W);
    assign legal     = route_legal(dir_e'(IN_TYPE), route);

    assign out_valid = out_full ? sel : '0;
    assign fire      = |(out_valid & out_ready);

    // One pop per cycle at most: an illegal head is discarded regardless of
    // the output register, a legal head moves only when the register frees.
    always_comb begin
        load     = 1'b0;
        drop     = 1'b0;
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (!legal) begin
                drop     = 1'b1;
                fifo_pop = 1'b1;
            end else if (!out_full || fire) begin
                load     = 1'b1;
                fifo_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_full   <= 1'b0;
            sel        <= '0;
            out_data   <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (load) begin
                out_full <= 1'b1;
                sel      <= NUM_DIRS'(1) << route;
                out_data <= head;
            end else if (fire) begin
                out_full <= 1'b0;
            end
            drop_pulse <= drop;
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

    assign occupancy = OCC_W'(fifo_count) + OCC_W'(out_full);

endmodule

// File: tb/tb_noc_input_router.sv
module tb_noc_input_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [32:0] in_data;
    logic [4:0]  out_ready;

    // One instance per input direction (index == IN_TYPE).
    logic [4:0]  rdy;
    logic [4:0]  ov  [5];
    logic [32:0] od  [5];
    logic [2:0]  occ [5];
    logic [7:0]  cnt [5];
    logic [4:0]  dp;

    // Narrow-counter instance, input direction N.
    logic        s_rdy;
    logic [4:0]  s_ov;
    logic [32:0] s_od;
    logic [2:0]  s_occ;
    logic [1:0]  s_cnt;
    logic        s_dp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dut
            noc_input_router #(
                .WIDTH(33), .ADDR_W(4), .MY_ADDR(4'b0101),
                .IN_TYPE(3'(g)), .DEPTH(4), .CNT_W(8)
            ) u_dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .in_valid   (in_valid),
                .in_ready   (rdy[g]),
                .in_data    (in_data),
                .out_valid  (ov[g]),
                .out_ready  (out_ready),
                .out_data   (od[g]),
                .occupancy  (occ[g]),
                .drop_cnt   (cnt[g]),
                .drop_pulse (dp[g])
            );
        end
    endgenerate

    noc_input_router #(
        .WIDTH(33), .ADDR_W(4), .MY_ADDR(4'b0101),
        .IN_TYPE(3'd0), .DEPTH(4), .CNT_W(2)
    ) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_rdy),
        .in_data    (in_data),
        .out_valid  (s_ov),
        .out_ready  (out_ready),
        .out_data   (s_od),
        .occupancy  (s_occ),
        .drop_cnt   (s_cnt),
        .drop_pulse (s_dp)
    );

    typedef struct {
        logic [32:0]      pkt;
        logic [4:0][4:0]  exp_ov;   // expected out_valid per IN_TYPE, 0 = dropped
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32:0] pk(input logic [3:0] dest, input logic [23:0] data);
        return {1'b1, dest, 4'b0101, data};
    endfunction

    function automatic vec_t mk(input logic [32:0] p, input logic [4:0] n, input logic [4:0] e,
                                input logic [4:0] s, input logic [4:0] w, input logic [4:0] pe);
        vec_t v;
        v.pkt       = p;
        v.exp_ov[0] = n;
        v.exp_ov[1] = e;
        v.exp_ov[2] = s;
        v.exp_ov[3] = w;
        v.exp_ov[4] = pe;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        int          exp_cnt [5];
        logic [4:0]  e;
        logic [32:0] p;
        int          nacc;
        int          pulses;
        logic        acc;

        // Routes from MY_ADDR 0101 (x=1, y=1)
        vecs[0] = mk(33'b100100101110100101110010110111000,           // dest 0010 -> W
                     5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b01000);
        vecs[1] = mk(pk(4'b0101, 24'h111111),                          // -> PE
                     5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00000);
        vecs[2] = mk(pk(4'b1101, 24'h222222),                          // x=3 -> E
                     5'b00000, 5'b00000, 5'b00000, 5'b00010, 5'b00010);
        vecs[3] = mk(pk(4'b0111, 24'h333333),                          // y=3 -> N
                     5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001);
        vecs[4] = mk(pk(4'b0100, 24'h444444),                          // y=0 -> S
                     5'b00100, 5'b00100, 5'b00000, 5'b00100, 5'b00100);
        for (int i = 0; i < 5; i++) exp_cnt[i] = 0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = '0;

        #12;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("reset_in_ready[%0d]", i), 64'(rdy[i]), 64'd0);
            chk($sformatf("reset_out_valid[%0d]", i), 64'(ov[i]), 64'd0);
            chk($sformatf("reset_out_data[%0d]", i), 64'(od[i]), 64'd0);
            chk($sformatf("reset_occupancy[%0d]", i), 64'(occ[i]), 64'd0);
            chk($sformatf("reset_drop_cnt[%0d]", i), 64'(cnt[i]), 64'd0);
            chk($sformatf("reset_drop_pulse[%0d]", i), 64'(dp[i]), 64'd0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_release", 64'(rdy), 64'h1f);

        // Table: one packet per vector into every direction, outputs ready.
        out_ready = 5'h1f;
        for (int v = 0; v < 5; v++) begin
            in_data  = vecs[v].pkt;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            for (int i = 0; i < 5; i++) begin
                e = vecs[v].exp_ov[i];
                if (e == 5'b0) exp_cnt[i]++;
                chk($sformatf("v%0d_out_valid[%0d]", v, i), 64'(ov[i]), 64'(e));
                chk($sformatf("v%0d_drop_pulse[%0d]", v, i), 64'(dp[i]), 64'(e == 5'b0));
                chk($sformatf("v%0d_drop_cnt[%0d]", v, i), 64'(cnt[i]), 64'(exp_cnt[i]));
                chk($sformatf("v%0d_occupancy[%0d]", v, i), 64'(occ[i]), 64'(e != 5'b0));
                if (e != 5'b0)
                    chk($sformatf("v%0d_out_data[%0d]", v, i), 64'(od[i]), 64'(vecs[v].pkt));
            end
            tick();
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("v%0d_drained_valid[%0d]", v, i), 64'(ov[i]), 64'd0);
                chk($sformatf("v%0d_drained_pulse[%0d]", v, i), 64'(dp[i]), 64'd0);
            end
        end

        // Backpressure on the E input: 6 offered, 5 fit (4 FIFO + register).
        out_ready = 5'b0;
        nacc = 0;
        for (int n = 0; n < 6; n++) begin
            in_data  = pk(4'b0010, 24'(100 + n));
            in_valid = 1'b1;
            acc      = rdy[1];
            tick();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(nacc), 64'd5);
        chk("bp_in_ready_low", 64'(rdy[1]), 64'd0);
        chk("bp_occupancy", 64'(occ[1]), 64'd5);
        chk("bp_out_valid", 64'(ov[1]), 64'b01000);
        chk("bp_out_data", 64'(od[1]), 64'(pk(4'b0010, 24'd100)));

        // Ready on every output except the selected one must not fire.
        out_ready = 5'b10111;
        tick();
        tick();
        chk("bp_other_ready_occ", 64'(occ[1]), 64'd5);
        chk("bp_stable_valid", 64'(ov[1]), 64'b01000);
        chk("bp_stable_data", 64'(od[1]), 64'(pk(4'b0010, 24'd100)));

        out_ready = 5'h1f;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("drain%0d_valid", j), 64'(ov[1]), 64'b01000);
            chk($sformatf("drain%0d_data", j), 64'(od[1]), 64'(pk(4'b0010, 24'(100 + j))));
            chk($sformatf("drain%0d_occ", j), 64'(occ[1]), 64'(5 - j));
            tick();
        end
        chk("drain_end_valid", 64'(ov[1]), 64'd0);
        chk("drain_end_occ", 64'(occ[1]), 64'd0);
        chk("drain_end_ready", 64'(rdy[1]), 64'd1);

        // Mid-cycle reset with three packets held in the E input.
        out_ready = 5'b0;
        for (int n = 0; n < 3; n++) begin
            in_data  = pk(4'b0010, 24'(200 + n));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_occ", 64'(occ[1]), 64'd3);
        chk("pre_reset_cnt_n", 64'(cnt[0] != 8'd0), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(ov[1]), 64'd0);
        chk("async_occ", 64'(occ[1]), 64'd0);
        chk("async_out_data", 64'(od[1]), 64'd0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("async_drop_cnt[%0d]", i), 64'(cnt[i]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_reset_ready", 64'(rdy[1]), 64'd1);
        chk("post_reset_occ", 64'(occ[1]), 64'd0);
        out_ready = 5'h1f;
        p = pk(4'b0101, 24'h00abcd);
        in_data  = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_reset_valid", 64'(ov[1]), 64'b10000);
        chk("post_reset_data", 64'(od[1]), 64'(p));
        tick();
        chk("post_reset_no_stale_valid", 64'(ov[1]), 64'd0);
        chk("post_reset_no_stale_occ", 64'(occ[1]), 64'd0);

        // Saturation of a 2-bit drop counter with 5 back-to-back drops.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("sat_start_cnt", 64'(s_cnt), 64'd0);
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            in_data  = vecs[0].pkt;
            in_valid = 1'b1;
            tick();
            pulses += int'(s_dp);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            pulses += int'(s_dp);
        end
        chk("sat_pulses", 64'(pulses), 64'd5);
        chk("sat_drop_cnt", 64'(s_cnt), 64'd3);
        chk("sat_out_valid", 64'(s_ov), 64'd0);
        chk("sat_occupancy", 64'(s_occ), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
